// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide unit:
//     - 4-bit operation encodings used on muldiv_unit.op
//     - FSM state enum and operation-class enum
//     - decodeOp(): maps an op code to its class (unknown codes -> CLS_NONE)
//     - cntWidth(): latency counter width, clog2(max latency + 1)
//   Configuration macro: MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU
//   codes. When it is undefined, those codes decode as CLS_NONE (no-ops).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MUL  = 3'd1,
    CLS_DIV  = 3'd2,
    CLS_MTHI = 3'd3,
    CLS_MTLO = 3'd4
  } opClass_t;

  function automatic opClass_t decodeOp(input logic [3:0] op);
    opClass_t cls;
    case (op)
      OP_MULT, OP_MULTU: cls = CLS_MUL;
      OP_DIV, OP_DIVU:   cls = CLS_DIV;
      OP_MTHI:           cls = CLS_MTHI;
      OP_MTLO:           cls = CLS_MTLO;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU: cls = CLS_MUL;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // Width able to hold the largest latency value loaded into the counter.
  function automatic int cntWidth(input int mulLat, input int divLat);
    int maxLat;
    maxLat = (mulLat > divLat) ? mulLat : divLat;
    return $clog2(maxLat + 1);
  endfunction

endpackage : muldiv_pkg

// File: rtl/muldiv_arith.sv
// -----------------------------------------------------------------------------
// muldiv_arith
//   Purely combinational result generator for the HI/LO unit.
//   Parameters: WIDTH - operand / HI / LO width.
//   Ports:
//     op     in  4      operation code (muldiv_pkg encodings)
//     a, b   in  WIDTH  rs / rt operands
//     accHi  in  WIDTH  current HI, accumulate base (MULDIV_MADD_EN only)
//     accLo  in  WIDTH  current LO, accumulate base (MULDIV_MADD_EN only)
//     resHi  out WIDTH  result destined for HI
//     resLo  out WIDTH  result destined for LO
//   Multiply: full 2*WIDTH product, signed or unsigned.
//   Divide: quotient truncated toward zero, remainder takes the dividend's
//   sign; divide by zero gives LO = all ones, HI = a.
//   MULDIV_MADD_EN adds {accHi,accLo} +/- product, mod 2^(2*WIDTH); without
//   it the accumulate ports and adder do not exist.
// -----------------------------------------------------------------------------
module muldiv_arith
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MADD_EN
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
`endif
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  localparam int W2 = 2 * WIDTH;

  logic             signedOp;
  logic [W2-1:0]    mulA;
  logic [W2-1:0]    mulB;
  logic [W2-1:0]    product;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] magQuot;
  logic [WIDTH-1:0] magRem;
  logic [WIDTH-1:0] divQuot;
  logic [WIDTH-1:0] divRem;

  assign signedOp = (op == OP_MULT) || (op == OP_DIV) ||
                    (op == OP_MADD) || (op == OP_MSUB);

  // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
  // the product gives the exact signed or unsigned result.
  assign mulA    = signedOp ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign mulB    = signedOp ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign product = mulA * mulB;

  // One unsigned divider serves both flavours: signed operands are divided
  // as magnitudes and the signs are reapplied afterwards. MIN / -1 needs no
  // extra logic: |MIN| / 1 = 2^(WIDTH-1), which is the MIN bit pattern, with
  // a positive quotient sign and a zero remainder.
  assign negA    = signedOp & a[WIDTH-1];
  assign negB    = signedOp & b[WIDTH-1];
  assign magA    = negA ? (~a + 1'b1) : a;
  assign magB    = negB ? (~b + 1'b1) : b;
  assign magQuot = (magB == '0) ? '0 : (magA / magB);
  assign magRem  = (magB == '0) ? '0 : (magA % magB);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    divQuot = (negA ^ negB) ? (~magQuot + 1'b1) : magQuot;
    divRem  = negA ? (~magRem + 1'b1) : magRem;
    if (b == '0) begin
      divQuot = '1;
      divRem  = a;
    end
  end

`ifdef MULDIV_MADD_EN
  logic [W2-1:0] accSum;
  logic          accSub;

  assign accSub = (op == OP_MSUB) || (op == OP_MSUBU);
  assign accSum = accSub ? ({accHi, accLo} - product)
                         : ({accHi, accLo} + product);
`endif

  always_comb begin
    resHi = '0;
    resLo = '0;
    case (op)
      OP_MULT, OP_MULTU: {resHi, resLo} = product;
      OP_DIV, OP_DIVU: begin
        resHi = divRem;
        resLo = divQuot;
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU: {resHi, resLo} = accSum;
`endif
      default: ;
    endcase
  end

endmodule : muldiv_arith

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   HI/LO multiply/divide unit for the execute stage. One operation is
//   accepted per start pulse while idle; its result is computed at accept,
//   held in pending registers for MUL_LAT or DIV_LAT unfrozen cycles, then
//   committed to architectural HI/LO. MTHI/MTLO write HI/LO at accept.
//   Parameters: WIDTH (even, >= 8), MUL_LAT (>= 1), DIV_LAT (>= 1).
//   Ports:
//     clk     in  1      clock, rising edge
//     reset   in  1      asynchronous active-high reset, clears all state
//     freeze  in  1      holds all state; start ignored
//     start   in  1      operation valid this cycle
//     op      in  4      operation code (muldiv_pkg)
//     a, b    in  WIDTH  rs / rt operands
//     busy    out 1      operation in flight (registered)
//     hi, lo  out WIDTH  architectural HI / LO (registered)
//   Configuration macro: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU,
//   accumulating onto the HI/LO values present at accept.
//   A start while busy is dropped without any state change.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cntWidth(MUL_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic [WIDTH-1:0] pendHi, pendHiNext;
  logic [WIDTH-1:0] pendLo, pendLoNext;
  logic [WIDTH-1:0] hiNext, loNext;
  logic [WIDTH-1:0] resHi, resLo;
  opClass_t         opClass;

  assign opClass = decodeOp(op);

  muldiv_arith #(
    .WIDTH (WIDTH)
  ) uArith (
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MULDIV_MADD_EN
    .accHi (hi),
    .accLo (lo),
`endif
    .resHi (resHi),
    .resLo (resLo)
  );

  always_comb begin
    stateNext  = state;
    countNext  = count;
    pendHiNext = pendHi;
    pendLoNext = pendLo;
    hiNext     = hi;
    loNext     = lo;
    if (!freeze) begin
      case (state)
        IDLE: begin
          if (start) begin
            case (opClass)
              CLS_MTHI: hiNext = a;
              CLS_MTLO: loNext = a;
              CLS_MUL: begin
                pendHiNext = resHi;
                pendLoNext = resLo;
                countNext  = MUL_CNT;
                stateNext  = BUSY;
              end
              CLS_DIV: begin
                pendHiNext = resHi;
                pendLoNext = resLo;
                countNext  = DIV_CNT;
                stateNext  = BUSY;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          countNext = count - CNT_ONE;
          // The edge that takes the counter to zero is the commit edge.
          if (count == CNT_ONE) begin
            hiNext    = pendHi;
            loNext    = pendLo;
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      pendHi <= '0;
      pendLo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state  <= stateNext;
      count  <= countNext;
      pendHi <= pendHiNext;
      pendLo <= pendLoNext;
      hi     <= hiNext;
      lo     <= loNext;
    end
  end

  assign busy = (state == BUSY);

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=5,
//   DIV_LAT=10). Inputs change on the falling edge; outputs are sampled 1
//   time unit after the rising edge. MADD checks follow MULDIV_MADD_EN.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             freeze = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       op = 4'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int nChecks = 0;
  int nFails  = 0;

  muldiv_unit #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Present one operation for a single rising edge, then scramble operands
  // so the result can only come from what was sampled at accept.
  task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  // Count rising edges until busy falls (bounded).
  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    idleCycles(3);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    nChecks++; if (hi !== 32'h0) begin nFails++; $display("FAIL reset_hi: got %h want 0", hi); end
    nChecks++; if (lo !== 32'h0) begin nFails++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk); reset = 1'b0;
    idleCycles(1);
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL mult_busy_rise: got %0b want 1", busy); end
    nChecks++; if (lo !== 32'h0) begin nFails++; $display("FAIL mult_lo_early: got %h want 0", lo); end
    countBusy(n);
    nChecks++; if (n != MUL_LAT) begin nFails++; $display("FAIL mult_latency: got %0d want %0d", n, MUL_LAT); end
    nChecks++; if (hi !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    nChecks++; if (lo !== 32'hFFFF_FFEB) begin nFails++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    countBusy(n);
    nChecks++; if (hi !== 32'hFFFF_FFFE) begin nFails++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    nChecks++; if (lo !== 32'h0000_0001) begin nFails++; $display("FAIL multu_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    countBusy(n);
    nChecks++; if (n != DIV_LAT) begin nFails++; $display("FAIL divu_latency: got %0d want %0d", n, DIV_LAT); end
    nChecks++; if (lo !== 32'd14) begin nFails++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    nChecks++; if (hi !== 32'd2) begin nFails++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    countBusy(n);
    nChecks++; if (lo !== 32'hFFFF_FFFD) begin nFails++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    nChecks++; if (hi !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    countBusy(n);
    nChecks++; if (lo !== 32'hFFFF_FFFD) begin nFails++; $display("FAIL div_negdiv_lo: got %h want fffffffd", lo); end
    nChecks++; if (hi !== 32'd1) begin nFails++; $display("FAIL div_negdiv_hi: got %h want 00000001", hi); end
    issue(OP_DIV, 32'd5, 32'd0);
    countBusy(n);
    nChecks++; if (lo !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL div_zero_lo: got %h want ffffffff", lo); end
    nChecks++; if (hi !== 32'd5) begin nFails++; $display("FAIL div_zero_hi: got %h want 00000005", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    countBusy(n);
    nChecks++; if (lo !== 32'h8000_0000) begin nFails++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    nChecks++; if (hi !== 32'd0) begin nFails++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_mthi();
    logic sawBusy;
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    nChecks++; if (hi !== 32'h0000_1234) begin nFails++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
    sawBusy = busy;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sawBusy = sawBusy | busy;
    end
    nChecks++; if (sawBusy !== 1'b0) begin nFails++; $display("FAIL mthi_busy: got %0b want 0", sawBusy); end
    issue(OP_MTLO, 32'h0000_5678, 32'd0);
    nChecks++; if (lo !== 32'h0000_5678) begin nFails++; $display("FAIL mtlo_lo: got %h want 00005678", lo); end
    nChecks++; if (hi !== 32'h0000_1234) begin nFails++; $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); end
  endtask

  task automatic test_unknown();
    issue(4'hF, 32'd1, 32'd1);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL unknown_busy: got %0b want 0", busy); end
    idleCycles(3);
    nChecks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin nFails++; $display("FAIL unknown_hilo: got %h want 0000123400005678", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OP_MULTU, 32'd3, 32'd4);
    idleCycles(1);
    issue(OP_DIVU, 32'd100, 32'd7);
    countBusy(n);
    nChecks++; if (n != MUL_LAT - 2) begin nFails++; $display("FAIL b2b_latency: got %0d want %0d", n, MUL_LAT - 2); end
    nChecks++; if ({hi, lo} !== 64'd12) begin nFails++; $display("FAIL b2b_result: got %h want 000000000000000c", {hi, lo}); end
    idleCycles(12);
    nChecks++; if (busy !== 1'b0 || {hi, lo} !== 64'd12) begin nFails++; $display("FAIL b2b_no_second: got busy=%0b hilo=%h want 0/000000000000000c", busy, {hi, lo}); end
  endtask

  task automatic test_freeze();
    int n;
    issue(OP_MULT, 32'd6, 32'd7);
    idleCycles(2);
    freeze = 1'b1;
    idleCycles(3);
    nChecks++; if (busy !== 1'b1 || lo !== 32'd12) begin nFails++; $display("FAIL freeze_hold: got busy=%0b lo=%h want 1/0000000c", busy, lo); end
    freeze = 1'b0;
    countBusy(n);
    nChecks++; if (n != MUL_LAT - 2) begin nFails++; $display("FAIL freeze_latency: got %0d more edges want %0d", n, MUL_LAT - 2); end
    nChecks++; if ({hi, lo} !== 64'd42) begin nFails++; $display("FAIL freeze_result: got %h want 000000000000002a", {hi, lo}); end
    @(negedge clk); freeze = 1'b1;
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    nChecks++; if (hi !== 32'd0) begin nFails++; $display("FAIL freeze_mthi: got %h want 00000000", hi); end
    @(negedge clk); freeze = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, 32'd100, 32'd7);
    idleCycles(1);
    reset = 1'b1;
    #1;
    nChecks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin nFails++; $display("FAIL reset_mid: got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    @(negedge clk); reset = 1'b0;
    idleCycles(15);
    nChecks++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin nFails++; $display("FAIL reset_no_commit: got busy=%0b hilo=%h want 0/0", busy, {hi, lo}); end
  endtask

  task automatic test_madd();
    int n;
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
    countBusy(n);
    nChecks++; if (n != MUL_LAT) begin nFails++; $display("FAIL maddu_latency: got %0d want %0d", n, MUL_LAT); end
    nChecks++; if (hi !== 32'd1 || lo !== 32'd0) begin nFails++; $display("FAIL maddu_result: got %h_%h want 00000001_00000000", hi, lo); end
    issue(OP_MSUB, 32'd2, 32'd3);
    countBusy(n);
    nChecks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFA) begin nFails++; $display("FAIL msub_result: got %h_%h want 00000000_fffffffa", hi, lo); end
`else
    n = 0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL maddu_off_busy: got %0b want 0", busy); end
    idleCycles(MUL_LAT + 1);
    nChecks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL maddu_off_hilo: got %h_%h want 00000000_ffffffff n=%0d", hi, lo, n); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_unknown();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_muldiv_unit
